// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/lr/sd in the 'clock' domain and de-serialises MSB-first stereo words.
// Optional EAR hysteresis comparator on the left channel is built when I2S_RX_EAR_EN is defined.
module i2s_rx #(
  parameter int            DW   = 16,
  parameter logic [DW-1:0] HYST = DW'(16'h0400)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sck,
  input  logic          lr,
  input  logic          sd,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] rdata,
  output logic          lstb,
  output logic          rstb,
  output logic          ear
);

  localparam int            CW   = $clog2(DW + 1);
  localparam logic [CW-1:0] FULL = CW'(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  // {sck, lr, sd} travel together so lr/sd stay aligned with the sck edge
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic          sck_dly_q, sck_dly_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] bits_q, bits_d;
  logic          lr_prev_q, lr_prev_d;
  logic          armed_q, armed_d;
  logic [DW-1:0] ldata_q, ldata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          lstb_q, lstb_d;
  logic          rstb_q, rstb_d;

  logic          rise;
  logic          lr_s;
  logic          sd_s;
  logic [DW-1:0] word;
  logic          word_full;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    sync1_d   = {sck, lr, sd};
    sync2_d   = sync1_q;
    sck_dly_d = sync2_q[2];
    rise      = sync2_q[2] & ~sck_dly_q;
    lr_s      = sync2_q[1];
    sd_s      = sync2_q[0];

    sr_d      = sr_q;
    bits_d    = bits_q;
    lr_prev_d = lr_prev_q;
    armed_d   = armed_q;
    ldata_d   = ldata_q;
    rdata_d   = rdata_q;
    lstb_d    = 1'b0;
    rstb_d    = 1'b0;
    word      = sr_q;
    word_full = 1'b0;

    if (rise) begin
      if (lr_s == lr_prev_q) begin
        // Bits beyond DW are slot padding and are dropped
        if (bits_q < FULL) begin
          sr_d   = {sr_q[DW-2:0], sd_s};
          bits_d = bits_q + CW'(1);
        end
      end else begin
        // One-bit delay: the bit on the word-select change is the closing word's LSB
        if (bits_q < FULL) begin
          word      = {sr_q[DW-2:0], sd_s};
          word_full = (bits_q == LAST);
        end else begin
          word      = sr_q;
          word_full = 1'b1;
        end

        if (armed_q && word_full) begin
          if (!lr_prev_q) begin
            ldata_d = word;
            lstb_d  = 1'b1;
          end else begin
            rdata_d = word;
            rstb_d  = 1'b1;
          end
        end

        bits_d    = '0;
        lr_prev_d = lr_s;
        armed_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sck_dly_q <= 1'b0;
      sr_q      <= '0;
      bits_q    <= '0;
      lr_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      ldata_q   <= '0;
      rdata_q   <= '0;
      lstb_q    <= 1'b0;
      rstb_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from before the edge.
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sck_dly_q <= sck_dly_d;
      sr_q      <= sr_d;
      bits_q    <= bits_d;
      lr_prev_q <= lr_prev_d;
      armed_q   <= armed_d;
      ldata_q   <= ldata_d;
      rdata_q   <= rdata_d;
      lstb_q    <= lstb_d;
      rstb_q    <= rstb_d;
    end
  end

  assign ldata = ldata_q;
  assign rdata = rdata_q;
  assign lstb  = lstb_q;
  assign rstb  = rstb_q;

`ifdef I2S_RX_EAR_EN
  localparam logic signed [DW-1:0] HYST_POS = HYST;
  localparam logic signed [DW-1:0] HYST_NEG = -HYST_POS;

  logic ear_q, ear_d;

  // Schmitt-style level recovery: inside the +/-HYST band the previous level holds
  always_comb begin
    ear_d = ear_q;
    if (lstb_q) begin
      if ($signed(ldata_q) > HYST_POS) begin
        ear_d = 1'b1;
      end else if ($signed(ldata_q) < HYST_NEG) begin
        ear_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ear_q <= 1'b0;
    end else begin
      ear_q <= ear_d;
    end
  end

  assign ear = ear_q;
`else
  assign ear = 1'b0;
`endif

endmodule
